// File: rtl/dac_code_sequencer_if.sv
// Producer / control / DAC-side bundle for the DAC code sequencer.
interface dac_code_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             en;
    logic [DIV_W-1:0] rate_div;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dig;
    logic             update;
    logic             underflow;
    logic             clr_uf;
    logic [LW-1:0]    level;

    modport master (
        output en, rate_div, in_data, in_valid, clr_uf,
        input  in_ready, dig, update, underflow, level
    );

    modport slave (
        input  en, rate_div, in_data, in_valid, clr_uf,
        output in_ready, dig, update, underflow, level
    );
endinterface

// File: rtl/dac_code_sequencer.sv
// Paced DAC code sequencer: sample FIFO drained into a registered R-2R code
// at one entry per (rate_div+1) clocks while enabled.
module dac_code_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input logic                clk,
    input logic                rst,
    dac_code_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] dig_q, dig_d;
    logic             update_q, update_d;
    logic             uf_q, uf_d;

    logic full, empty, push, pop, tick;

    // in_ready depends on level only, so a same-cycle pop never opens a full FIFO
    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign push     = bus.in_valid && !full;
    // en low drops to IDLE and suppresses the tick in the same cycle
    assign tick     = (state_q == S_RUN) && bus.en && (cnt_q == bus.rate_div);
    assign pop      = tick && !empty;

    assign bus.in_ready  = !full;
    assign bus.dig       = dig_q;
    assign bus.update    = update_q;
    assign bus.underflow = uf_q;
    assign bus.level     = level_q;

    // Run/idle control and the update-rate divider
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.en && !empty) state_d = S_RUN;
            end
            default: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
        endcase
    end

    // Sample FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // DAC code register, update strobe and sticky underflow (set beats clear)
    always_comb begin
        dig_d    = pop ? mem_q[rd_ptr_q] : dig_q;
        update_d = pop;
        if (tick && empty)   uf_d = 1'b1;
        else if (bus.clr_uf) uf_d = 1'b0;
        else                 uf_d = uf_q;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dig_q    <= '0;
            update_q <= 1'b0;
            uf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dig_q    <= dig_d;
            update_q <= update_d;
            uf_q     <= uf_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_dac_code_sequencer.sv
// Directed bench for dac_code_sequencer (WIDTH=8, DEPTH=4, DIV_W=16).
module tb_dac_code_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dac_code_sequencer_if #(.WIDTH(8), .DEPTH(4), .DIV_W(16)) bus ();

    dac_code_sequencer #(.WIDTH(8), .DEPTH(4), .DIV_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock, land 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_code(input logic [7:0] c);
        bus.in_valid = 1'b1;
        bus.in_data  = c;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.dig !== 8'h00)   begin errors++; $display("FAIL reset_dig got %h exp 00", bus.dig); end
        checks++; if (bus.level !== 3'd0)  begin errors++; $display("FAIL reset_level got %0d exp 0", bus.level); end
        checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL reset_update got %b exp 0", bus.update); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_uf got %b exp 0", bus.underflow); end
        rst = 1'b0;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    // three codes at rate_div=3: dig changes after steps 5, 9, 13 from en
    task automatic test_basic();
        logic [7:0] exp_dig;
        logic       exp_upd;
        bus.rate_div = 16'd3;
        push_code(8'h10);
        push_code(8'h20);
        push_code(8'h30);
        checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL basic_level got %0d exp 3", bus.level); end
        bus.en = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            exp_dig = (i >= 13) ? 8'h30 : (i >= 9) ? 8'h20 : (i >= 5) ? 8'h10 : 8'h00;
            exp_upd = (i == 5) || (i == 9) || (i == 13);
            checks++; if (bus.dig !== exp_dig) begin errors++; $display("FAIL basic_dig step %0d got %h exp %h", i, bus.dig, exp_dig); end
            checks++; if (bus.update !== exp_upd) begin errors++; $display("FAIL basic_update step %0d got %b exp %b", i, bus.update, exp_upd); end
        end
        bus.en = 1'b0;
        step();
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL basic_end_level got %0d exp 0", bus.level); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL basic_end_uf got %b exp 0", bus.underflow); end
    endtask

    // one sample then starvation; clear, then set-beats-clear, then stickiness
    task automatic test_underflow();
        bus.rate_div = 16'd2;
        push_code(8'hA5);
        bus.en = 1'b1;
        for (int i = 1; i <= 3; i++) step();
        checks++; if (bus.dig !== 8'h30) begin errors++; $display("FAIL uf_predig got %h exp 30", bus.dig); end
        step();
        checks++; if (bus.dig !== 8'hA5)   begin errors++; $display("FAIL uf_dig got %h exp a5", bus.dig); end
        checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL uf_update got %b exp 1", bus.update); end
        step(); step();
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL uf_early got %b exp 0", bus.underflow); end
        step();
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b exp 1", bus.underflow); end
        checks++; if (bus.dig !== 8'hA5)   begin errors++; $display("FAIL uf_dig_held got %h exp a5", bus.dig); end
        checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL uf_no_update got %b exp 0", bus.update); end
        bus.clr_uf = 1'b1;
        step();
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL uf_clr got %b exp 0", bus.underflow); end
        step(); step();
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins got %b exp 1", bus.underflow); end
        bus.clr_uf = 1'b0;
        bus.en     = 1'b0;
        step();
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", bus.underflow); end
        bus.clr_uf = 1'b1;
        step();
        bus.clr_uf = 1'b0;
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL uf_clr2 got %b exp 0", bus.underflow); end
    endtask

    // fill to DEPTH, hold a fifth valid, then drain at rate_div=0
    task automatic test_full_stall();
        push_code(8'hB1); push_code(8'hB2); push_code(8'hB3); push_code(8'hB4);
        checks++; if (bus.level !== 3'd4)    begin errors++; $display("FAIL full_level got %0d exp 4", bus.level); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB5;
        step(); step();
        checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL stall_level got %0d exp 4", bus.level); end
        bus.rate_div = 16'd0;
        bus.en       = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", bus.in_ready); end
        step();
        checks++; if (bus.dig !== 8'hB1)     begin errors++; $display("FAIL drain_dig1 got %h exp b1", bus.dig); end
        checks++; if (bus.level !== 3'd3)    begin errors++; $display("FAIL drain_level1 got %0d exp 3", bus.level); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.dig !== 8'hB2)  begin errors++; $display("FAIL drain_dig2 got %h exp b2", bus.dig); end
        checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL drain_level2 got %0d exp 3", bus.level); end
        step(); step();
        checks++; if (bus.dig !== 8'hB4)  begin errors++; $display("FAIL drain_dig4 got %h exp b4", bus.dig); end
        step();
        checks++; if (bus.dig !== 8'hB5)  begin errors++; $display("FAIL drain_dig5 got %h exp b5", bus.dig); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL drain_level5 got %0d exp 0", bus.level); end
        bus.en     = 1'b0;
        bus.clr_uf = 1'b1;
        step();
        bus.clr_uf = 1'b0;
    endtask

    // pause with two queued, resume, then same-cycle push and pop at level 2
    task automatic test_pause_and_back_to_back();
        bus.rate_div = 16'd1;
        push_code(8'hC1); push_code(8'hC2); push_code(8'hC3); push_code(8'hC4);
        bus.en = 1'b1;
        for (int i = 1; i <= 5; i++) step();
        checks++; if (bus.dig !== 8'hC2)  begin errors++; $display("FAIL pause_pre_dig got %h exp c2", bus.dig); end
        bus.en = 1'b0;
        for (int i = 1; i <= 3; i++) step();
        checks++; if (bus.dig !== 8'hC2)   begin errors++; $display("FAIL pause_dig got %h exp c2", bus.dig); end
        checks++; if (bus.level !== 3'd2)  begin errors++; $display("FAIL pause_level got %0d exp 2", bus.level); end
        checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL pause_update got %b exp 0", bus.update); end
        bus.en = 1'b1;
        step(); step();
        checks++; if (bus.dig !== 8'hC2) begin errors++; $display("FAIL resume_early got %h exp c2", bus.dig); end
        step();
        checks++; if (bus.dig !== 8'hC3)  begin errors++; $display("FAIL resume_dig got %h exp c3", bus.dig); end
        bus.en = 1'b0;
        step();
        push_code(8'hC5);
        checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL b2b_pre_level got %0d exp 2", bus.level); end
        bus.en = 1'b1;
        step(); step();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC6;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.dig !== 8'hC4)  begin errors++; $display("FAIL b2b_pop got %h exp c4", bus.dig); end
        checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL b2b_level got %0d exp 2", bus.level); end
        step(); step();
        checks++; if (bus.dig !== 8'hC5) begin errors++; $display("FAIL b2b_next got %h exp c5", bus.dig); end
        step(); step();
        checks++; if (bus.dig !== 8'hC6)  begin errors++; $display("FAIL b2b_last got %h exp c6", bus.dig); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL b2b_end_level got %0d exp 0", bus.level); end
        bus.en = 1'b0;
        step();
    endtask

    // async reset mid-cycle while running; restart needs a fresh push
    task automatic test_async_reset();
        bus.rate_div = 16'd5;
        push_code(8'h7F); push_code(8'h01); push_code(8'h02); push_code(8'h03);
        bus.en = 1'b1;
        for (int i = 1; i <= 7; i++) step();
        checks++; if (bus.dig !== 8'h7F)  begin errors++; $display("FAIL ar_pre_dig got %h exp 7f", bus.dig); end
        checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL ar_pre_level got %0d exp 3", bus.level); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.dig !== 8'h00)      begin errors++; $display("FAIL ar_dig got %h exp 00", bus.dig); end
        checks++; if (bus.level !== 3'd0)     begin errors++; $display("FAIL ar_level got %0d exp 0", bus.level); end
        checks++; if (bus.update !== 1'b0)    begin errors++; $display("FAIL ar_update got %b exp 0", bus.update); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL ar_uf got %b exp 0", bus.underflow); end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++; if (bus.update !== 1'b0) begin errors++; $display("FAIL ar_idle_update step %0d got %b exp 0", i, bus.update); end
        end
        push_code(8'h44);
        for (int i = 1; i <= 6; i++) step();
        checks++; if (bus.dig !== 8'h00) begin errors++; $display("FAIL ar_restart_early got %h exp 00", bus.dig); end
        step();
        checks++; if (bus.dig !== 8'h44)   begin errors++; $display("FAIL ar_restart_dig got %h exp 44", bus.dig); end
        checks++; if (bus.update !== 1'b1) begin errors++; $display("FAIL ar_restart_update got %b exp 1", bus.update); end
        bus.en = 1'b0;
        step();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.rate_div = '0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.clr_uf   = 1'b0;
        test_reset();
        test_basic();
        test_underflow();
        test_full_stall();
        test_pause_and_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_code_sequencer.md
DAC_CODE_SEQUENCER -- requirements
Module: dac_code_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, width of the DAC code driven to the R-2R ladder.
REQ-002 Parameter DEPTH, default 4, sample FIFO entries, power of two, >= 2.
REQ-003 Parameter DIV_W, default 16, width of the update-rate divider.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  run enable; 0 = sequencer idle, code held.
REQ-007 rate_div  input  DIV_W  update period minus one, in clk cycles; sampled at each tick.
REQ-008 in_data  input  WIDTH  next DAC code from producer.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  FIFO can accept; transfer when in_valid && in_ready.
REQ-011 dig  output  WIDTH  registered code to R-2R DAC dig input.
REQ-012 update  output  1  one-cycle pulse, high in the cycle dig takes a new value.
REQ-013 underflow  output  1  sticky flag, a tick found the FIFO empty.
REQ-014 clr_uf  input  1  synchronous clear of underflow.
REQ-015 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 FIFO SHALL be DEPTH-entry, in-order; in_ready = (level != DEPTH), combinational from level only.
REQ-017 Push when full SHALL not occur even if a pop happens the same cycle; push and pop together when not full/not empty SHALL leave level unchanged.
REQ-018 States SHALL be IDLE and RUN; IDLE->RUN when en=1 and level>=1; RUN->IDLE whenever en=0 (checked every cycle, priority over tick).
REQ-019 Divider counter SHALL be 0 in IDLE; in RUN it counts 0..rate_div, tick asserted in the cycle count==rate_div, then wraps to 0.
REQ-020 rate_div=0 SHALL give a tick every RUN cycle; a rate_div change takes effect when count is next compared, no restart.
REQ-021 First tick after IDLE->RUN SHALL occur rate_div+1 cycles after entering RUN (count starts at 0 in first RUN cycle).
REQ-022 On tick with level>=1: FIFO head popped, dig <= head on that edge, update=1 in the following cycle only.
REQ-023 On tick with level==0: dig held, update stays 0, underflow <= 1, state stays RUN, counter keeps counting.
REQ-024 underflow SHALL stay 1 until clr_uf=1 or rst; set and clr_uf in same cycle -> set wins.
REQ-025 In IDLE dig SHALL hold its last value; FIFO contents SHALL be retained and pushes still accepted.
REQ-026 Latency in_data to dig SHALL be at least 1 cycle (no combinational path in_data->dig).
REQ-027 level SHALL never exceed DEPTH nor wrap below 0; read/write pointers wrap modulo DEPTH.

Reset
REQ-028 rst=1 SHALL asynchronously force: state IDLE, counter 0, FIFO empty (level 0), dig 0, update 0, underflow 0.
REQ-029 in_ready SHALL be 1 after reset deasserts (FIFO empty), 0 is never driven from an uninitialised value.
REQ-030 rst asserted mid-RUN SHALL discard queued samples and pending tick; first update after release needs a fresh push and tick.

Verification
REQ-031 Reset release, push 0x10,0x20,0x30, en=1, rate_div=3 -> dig 0x10,0x20,0x30 at 4-cycle spacing, update pulse each, first 4 cycles after RUN entry.
REQ-032 Push 4 codes with en=0 -> in_ready=0, level=4; fifth in_valid held stalls; en=1, rate_div=0 -> one pop per cycle, in_ready returns next cycle.
REQ-033 rate_div=2, one sample 0xA5 then none -> dig=0xA5, next tick underflow=1, dig stays 0xA5, no update; clr_uf -> underflow=0.
REQ-034 en dropped mid-RUN with level=2 -> IDLE, dig held, level stays 2; en=1 -> resumes in order after rate_div+1 cycles.
REQ-035 rst asserted between edges during RUN with level=3, dig=0x7F -> dig=0, level=0, update=0, underflow=0 immediately, no clk edge needed.
REQ-036 Same-cycle push and tick pop at level=2 -> level stays 2, popped value is oldest entry, pushed value queued last.
